pipelined_addsub: RTL and testbench

//  Parametrised, pipelined carry-lookahead add/subtract unit; next generation of the 32-bit combinational adder.

---
 rtl/pipelined_addsub.sv | 242 ++++++++++++++++++++++++
 tb/tb_pipelined_addsub.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined segmented carry-lookahead add/subtract unit with flags and valid/ready
//
// Purpose:
//   WIDTH-bit ADD/SUB/ADC/SBB split into NSTG = WIDTH/SEG segments, one segment
//   added per pipeline stage with the carry registered between stages. Results
//   and flags are registered at the output; latency is NSTG cycles, throughput
//   one beat per cycle, with full backpressure from out_ready.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand beat handshake
//   in_a, in_b            operands
//   in_op                 00 ADD, 01 SUB, 10 ADC, 11 SBB
//   in_cin                carry (ADC) / borrow (SBB) in
//   out_valid/out_ready   result beat handshake
//   out_s                 result
//   out_cf, out_of        raw carry-out of MSB, signed overflow
//   out_zf, out_sf        zero / sign of the delivered result
//   out_sat               saturation applied
//
// Configuration macro: ALU_SAT_EN enables signed saturation on overflow.

module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_cf,
    output logic             out_of,
    output logic             out_zf,
    output logic             out_sf,
    output logic             out_sat
);

    localparam int NSTG = WIDTH / SEG;
    localparam int NGRP = SEG / 4;
    localparam int LAST = NSTG - 1;

    // One SEG-bit segment built from 4-bit lookahead groups; groups chained
    // through their group generate/propagate terms.
    // Returns {carry out of segment, carry into segment MSB, sum}.
    function automatic logic [SEG+1:0] cla_seg(input logic [SEG-1:0] a,
                                                input logic [SEG-1:0] b,
                                                input logic           ci);
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG:0]   c;
        logic           gg;
        logic           gp;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        for (int j = 0; j < NGRP; j++) begin
            c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
            gg = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp = &p[4*j +: 4];
            c[4*j+4] = gg | (gp & c[4*j]);
        end
        return {c[SEG], c[SEG-1], p ^ c[SEG-1:0]};
    endfunction

    // Stage register k holds the beat about to have segment k added:
    // A (skewed), B already inverted for SUB/SBB, result segments below k
    // (deskew), carry into segment k and the running zero flag.
    logic             v_q [NSTG];
    logic [WIDTH-1:0] a_q [NSTG];
    logic [WIDTH-1:0] b_q [NSTG];
    logic [WIDTH-1:0] s_q [NSTG];
    logic             c_q [NSTG];
    logic             z_q [NSTG];

    logic             v_d [NSTG];
    logic [WIDTH-1:0] a_d [NSTG];
    logic [WIDTH-1:0] b_d [NSTG];
    logic [WIDTH-1:0] s_d [NSTG];
    logic             c_d [NSTG];
    logic             z_d [NSTG];

    logic [SEG+1:0]   seg_r [NSTG];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_s_q, out_s_d;
    logic             out_cf_q, out_cf_d;
    logic             out_of_q, out_of_d;
    logic             out_zf_q, out_zf_d;
    logic             out_sf_q, out_sf_d;
    logic             out_sat_q, out_sat_d;

    logic             advance;
    logic             accept;
    logic             op_m;
    logic             op_cin;

    logic [WIDTH-1:0] raw_s;
    logic [WIDTH-1:0] fin_s;
    logic             fin_cf;
    logic             fin_of;
    logic             fin_sat;
    logic             fin_zf;

    // The whole pipe moves in lockstep; a stalled output freezes every stage.
    assign advance  = ~out_valid_q | out_ready;
    assign in_ready = advance;
    assign accept   = in_valid & advance;

    // Subtraction is A + ~B + carry, so SUB injects 1 and SBB injects ~borrow.
    always_comb begin
        op_m = in_op[0];
        unique case (in_op)
            2'b00:   op_cin = 1'b0;
            2'b01:   op_cin = 1'b1;
            2'b10:   op_cin = in_cin;
            default: op_cin = ~in_cin;
        endcase
    end

    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            seg_r[k] = cla_seg(a_q[k][k*SEG +: SEG], b_q[k][k*SEG +: SEG], c_q[k]);
        end

        // Entry stage: operands only captured on acceptance.
        v_d[0] = in_valid;
        a_d[0] = accept ? in_a : a_q[0];
        b_d[0] = accept ? (in_b ^ {WIDTH{op_m}}) : b_q[0];
        s_d[0] = accept ? '0 : s_q[0];
        c_d[0] = accept ? op_cin : c_q[0];
        z_d[0] = accept ? 1'b1 : z_q[0];

        for (int k = 1; k < NSTG; k++) begin
            v_d[k]                   = v_q[k-1];
            a_d[k]                   = a_q[k-1];
            b_d[k]                   = b_q[k-1];
            s_d[k]                   = s_q[k-1];
            s_d[k][(k-1)*SEG +: SEG] = seg_r[k-1][SEG-1:0];
            c_d[k]                   = seg_r[k-1][SEG+1];
            z_d[k]                   = z_q[k-1] & (seg_r[k-1][SEG-1:0] == '0);
        end
    end

    // Final segment, flags and optional saturation.
    always_comb begin
        raw_s                    = s_q[LAST];
        raw_s[LAST*SEG +: SEG]   = seg_r[LAST][SEG-1:0];
        fin_cf                   = seg_r[LAST][SEG+1];
        // Carry into the MSB versus carry out of it.
        fin_of                   = seg_r[LAST][SEG+1] ^ seg_r[LAST][SEG];
`ifdef ALU_SAT_EN
        fin_sat = fin_of;
        if (fin_of) begin
            fin_s = a_q[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            fin_s = raw_s;
        end
`else
        fin_sat = 1'b0;
        fin_s   = raw_s;
`endif
        // A saturated value is never zero, so the raw zero chain just gets masked.
        fin_zf = z_q[LAST] & (seg_r[LAST][SEG-1:0] == '0) & ~fin_sat;
    end

    // Outputs reload only when a real beat arrives; bubbles leave them as-is.
    always_comb begin
        out_valid_d = v_q[LAST];
        out_s_d     = out_s_q;
        out_cf_d    = out_cf_q;
        out_of_d    = out_of_q;
        out_zf_d    = out_zf_q;
        out_sf_d    = out_sf_q;
        out_sat_d   = out_sat_q;
        if (v_q[LAST]) begin
            out_s_d   = fin_s;
            out_cf_d  = fin_cf;
            out_of_d  = fin_of;
            out_zf_d  = fin_zf;
            out_sf_d  = fin_s[WIDTH-1];
            out_sat_d = fin_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTG; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                z_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            out_s_q     <= '0;
            out_cf_q    <= 1'b0;
            out_of_q    <= 1'b0;
            out_zf_q    <= 1'b0;
            out_sf_q    <= 1'b0;
            out_sat_q   <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < NSTG; k++) begin
                v_q[k] <= v_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
                z_q[k] <= z_d[k];
            end
            out_valid_q <= out_valid_d;
            out_s_q     <= out_s_d;
            out_cf_q    <= out_cf_d;
            out_of_q    <= out_of_d;
            out_zf_q    <= out_zf_d;
            out_sf_q    <= out_sf_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_s     = out_s_q;
    assign out_cf    = out_cf_q;
    assign out_of    = out_of_q;
    assign out_zf    = out_zf_q;
    assign out_sf    = out_sf_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub (WIDTH=32, SEG=8)

module tb_pipelined_addsub;

    localparam int W    = 32;
    localparam int NSTG = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [1:0]    in_op;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_s;
    logic          out_cf;
    logic          out_of;
    logic          out_zf;
    logic          out_sf;
    logic          out_sat;

    pipelined_addsub #(.WIDTH(32), .SEG(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_cf    (out_cf),
        .out_of    (out_of),
        .out_zf    (out_zf),
        .out_sf    (out_sf),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] s;
        logic        cf;
        logic        of;
        logic        zf;
        logic        sf;
        logic        sat;
    } res_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        res_t        exp;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic res_t mkr(input logic [31:0] s, input logic cf, input logic of,
                                 input logic zf, input logic sf, input logic sat);
        res_t r;
        r.s = s; r.cf = cf; r.of = of; r.zf = zf; r.sf = sf; r.sat = sat;
        return r;
    endfunction

    // Reference: whole-word arithmetic on 33 bits, overflow from operand/result signs.
    function automatic res_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic cin);
        logic [31:0] bb;
        logic        c;
        logic [32:0] full;
        res_t        r;
        bb = op[0] ? ~b : b;
        case (op)
            2'd0:    c = 1'b0;
            2'd1:    c = 1'b1;
            2'd2:    c = cin;
            default: c = ~cin;
        endcase
        full  = {1'b0, a} + {1'b0, bb} + {32'd0, c};
        r.s   = full[31:0];
        r.cf  = full[32];
        r.of  = (a[31] == bb[31]) && (full[31] != a[31]);
        r.sat = 1'b0;
`ifdef ALU_SAT_EN
        if (r.of) begin
            r.sat = 1'b1;
            r.s   = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
`endif
        r.zf = (r.s == 32'd0);
        r.sf = r.s[31];
        return r;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic res_t cur_out();
        return mkr(out_s, out_cf, out_of, out_zf, out_sf, out_sat);
    endfunction

    vec_t tbl [11];
    res_t q[$];
    res_t stall_exp [4];

    initial begin
        int   lat;
        int   cyc;
        int   sent;
        int   got;
        logic stall_prev;
        logic seen;
        res_t held;
        res_t e;

        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = 2'd0;
        in_cin    = 1'b0;
        out_ready = 1'b0;

        tbl[0]  = '{2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, mkr(32'h8000_0000, 0, 1, 0, 1, 0)};
        tbl[1]  = '{2'd1, 32'h0000_0005, 32'h0000_0005, 1'b0, mkr(32'h0000_0000, 1, 0, 1, 0, 0)};
        tbl[2]  = '{2'd1, 32'h0000_0000, 32'h0000_0001, 1'b0, mkr(32'hFFFF_FFFF, 0, 0, 0, 1, 0)};
        tbl[3]  = '{2'd2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, mkr(32'h0000_0000, 1, 0, 1, 0, 0)};
        tbl[4]  = '{2'd3, 32'h0000_0010, 32'h0000_0001, 1'b1, mkr(32'h0000_000E, 1, 0, 0, 0, 0)};
        tbl[5]  = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, mkr(32'h0000_0000, 1, 0, 1, 0, 0)};
        tbl[6]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, mkr(32'h0000_0000, 1, 1, 1, 0, 0)};
        tbl[7]  = '{2'd1, 32'h8000_0000, 32'h0000_0001, 1'b0, mkr(32'h7FFF_FFFF, 1, 1, 0, 0, 0)};
        tbl[8]  = '{2'd0, 32'h0000_0001, 32'h0000_0001, 1'b1, mkr(32'h0000_0002, 0, 0, 0, 0, 0)};
        tbl[9]  = '{2'd1, 32'h0000_0003, 32'h0000_0001, 1'b1, mkr(32'h0000_0002, 1, 0, 0, 0, 0)};
        tbl[10] = '{2'd0, 32'h00FF_00FF, 32'h0001_0001, 1'b0, mkr(32'h0100_0100, 0, 0, 0, 0, 0)};
`ifdef ALU_SAT_EN
        tbl[0].exp = mkr(32'h7FFF_FFFF, 0, 1, 0, 0, 1);
        tbl[6].exp = mkr(32'h8000_0000, 1, 1, 0, 1, 1);
        tbl[7].exp = mkr(32'h8000_0000, 1, 1, 0, 1, 1);
`endif

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_outputs", 64'(cur_out()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: latency and result per vector
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_op     = tbl[i].op;
            in_a      = tbl[i].a;
            in_b      = tbl[i].b;
            in_cin    = tbl[i].cin;
            out_ready = 1'b1;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
            @(posedge clk);
            lat = 0;
            @(negedge clk);
            in_valid = 1'b0;
            in_a     = $urandom;
            in_b     = $urandom;
            while (out_valid !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(NSTG));
            chk($sformatf("vec%0d_result", i), 64'(cur_out()), 64'(tbl[i].exp));
        end
        @(negedge clk);

        // Stall with four beats in flight, then drain
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            in_valid     = 1'b1;
            in_op        = 2'($urandom_range(0, 3));
            in_a         = rand_operand();
            in_b         = rand_operand();
            in_cin       = 1'($urandom_range(0, 1));
            stall_exp[j] = model(in_op, in_a, in_b, in_cin);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_hold", 64'(cur_out()), 64'(stall_exp[0]));
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk($sformatf("drain%0d_valid", j), 64'(out_valid), 64'd1);
            chk($sformatf("drain%0d_result", j), 64'(cur_out()), 64'(stall_exp[j]));
            @(negedge clk);
        end
        chk("drain_done", 64'(out_valid), 64'd0);

        // Random traffic with random backpressure
        sent       = 0;
        got        = 0;
        cyc        = 0;
        stall_prev = 1'b0;
        held       = '0;
        while ((sent < 64 || q.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 64 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_op    = 2'($urandom_range(0, 3));
                in_a     = rand_operand();
                in_b     = rand_operand();
                in_cin   = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall_prev) begin
                chk("rand_hold", {27'd0, out_valid, 64'(cur_out())} , {27'd0, 1'b1, 64'(held)});
            end
            if (out_valid && out_ready) begin
                chk("rand_expected_pending", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk($sformatf("rand_beat%0d", got), 64'(cur_out()), 64'(e));
                    got++;
                end
            end
            stall_prev = out_valid & ~out_ready;
            held       = cur_out();
            if (in_valid && in_ready) begin
                q.push_back(model(in_op, in_a, in_b, in_cin));
                sent++;
            end
        end
        in_valid = 1'b0;
        chk("rand_count", 64'(got), 64'd64);
        chk("rand_queue_empty", 64'(q.size()), 64'd0);

        // Reset asserted with three beats in flight
        @(negedge clk);
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in_op    = 2'd0;
            in_a     = 32'h1234_0000 + 32'(j);
            in_b     = 32'h0000_1111;
            @(negedge clk);
        end
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("rst_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", 64'(cur_out()), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen      = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("rst_no_stale", 64'(seen), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
